// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM state encoding,
// default inactivity timeout and an index-width helper.
package uart_arb_pkg;

    localparam int STATE_W         = 2;
    localparam int TIMEOUT_DEFAULT = 1024;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_SETTLE = 2'd2
    } arb_state_e;

    // Bits needed to index n items; never less than one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot winner, search begins after last_winner.
// UART_ARB_PRIORITY_EN: requester 0 pre-empts the rotation whenever it requests.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] winner
);

    logic [NUM_REQ-1:0] rr_pick_s;
    logic               found_s;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int step);
        return IDX_W'((int'(base) + step) % NUM_REQ);
    endfunction

    // Rotating scan: the first requester found after the previous owner wins.
    always_comb begin
        rr_pick_s = '0;
        found_s   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_pick_s[wrap_idx(last_winner, k)] = req[wrap_idx(last_winner, k)] & ~found_s;
            found_s = found_s | req[wrap_idx(last_winner, k)];
        end
    end

    // Final selection, optionally letting requester 0 jump the queue.
    always_comb begin
`ifdef UART_ARB_PRIORITY_EN
        if (req[0]) begin
            winner = {{(NUM_REQ-1){1'b0}}, 1'b1};
        end else begin
            winner = rr_pick_s;
        end
`else
        winner = rr_pick_s;
`endif
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte-stream requesters, one message per grant.
// Build option UART_ARB_PRIORITY_EN gives requester 0 absolute priority at arbitration.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] byte_data,
    input  logic [NUM_REQ-1:0]   byte_valid,
    input  logic [NUM_REQ-1:0]   byte_last,
    output logic [NUM_REQ-1:0]   byte_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 new_tx_data,
    input  logic                 tx_busy
);

    localparam int               IDX_W      = idx_width(NUM_REQ);
    localparam int               CNT_W      = idx_width(TIMEOUT);
    localparam logic [IDX_W-1:0] RST_WINNER = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT - 1);

    arb_state_e         state_r, state_nx_s;
    logic [NUM_REQ-1:0] grant_r, grant_nx_s, winner_s, ready_s;
    logic [IDX_W-1:0]   owner_r, owner_nx_s, last_winner_r, last_winner_nx_s, winner_idx_s;
    logic [CNT_W-1:0]   idle_cnt_r, idle_cnt_nx_s;
    logic [7:0]         tx_data_r, tx_data_nx_s;
    logic               new_tx_r, new_tx_nx_s, last_byte_r, last_byte_nx_s;
    logic               accept_s, release_s;
    logic [7:0]         lane_s [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req         (req),
        .last_winner (last_winner_r),
        .winner      (winner_s)
    );

    // Split the packed byte bus into per-requester lanes and encode the winner.
    always_comb begin
        winner_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            lane_s[i]    = byte_data[8*i +: 8];
            winner_idx_s = winner_idx_s | (winner_s[i] ? IDX_W'(i) : '0);
        end
    end

    // Handshake: only the owner can be accepted, and only while it still requests.
    always_comb begin
        accept_s         = (state_r == ST_ACTIVE) && req[owner_r] && byte_valid[owner_r] && !tx_busy;
        ready_s          = '0;
        ready_s[owner_r] = accept_s;
    end

    // Next-state and next-output logic for the grant FSM.
    always_comb begin
        state_nx_s       = state_r;
        grant_nx_s       = grant_r;
        owner_nx_s       = owner_r;
        last_winner_nx_s = last_winner_r;
        idle_cnt_nx_s    = '0;
        tx_data_nx_s     = tx_data_r;
        new_tx_nx_s      = 1'b0;
        last_byte_nx_s   = last_byte_r;
        release_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_nx_s = ST_ACTIVE;
                    grant_nx_s = winner_s;
                    owner_nx_s = winner_idx_s;
                end else begin
                    grant_nx_s = '0;
                end
            end
            ST_ACTIVE: begin
                if (!req[owner_r]) begin
                    release_s = 1'b1;
                end else if (accept_s) begin
                    state_nx_s     = ST_SETTLE;
                    tx_data_nx_s   = lane_s[owner_r];
                    new_tx_nx_s    = 1'b1;
                    last_byte_nx_s = byte_last[owner_r];
                end else if (idle_cnt_r == CNT_MAX) begin
                    release_s = 1'b1;
                end else begin
                    idle_cnt_nx_s = idle_cnt_r + 1'b1;
                end
            end
            ST_SETTLE: begin
                // One cycle for the transmitter's busy flag to rise before the next byte.
                if (last_byte_r) begin
                    release_s = 1'b1;
                end else begin
                    state_nx_s = ST_ACTIVE;
                end
            end
            default: begin
                release_s = 1'b1;
            end
        endcase
        state_nx_s       = release_s ? ST_IDLE : state_nx_s;
        grant_nx_s       = release_s ? '0 : grant_nx_s;
        last_winner_nx_s = release_s ? owner_r : last_winner_nx_s;
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            grant_r       <= '0;
            owner_r       <= '0;
            last_winner_r <= RST_WINNER;
            idle_cnt_r    <= '0;
            tx_data_r     <= 8'h00;
            new_tx_r      <= 1'b0;
            last_byte_r   <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            grant_r       <= grant_nx_s;
            owner_r       <= owner_nx_s;
            last_winner_r <= last_winner_nx_s;
            idle_cnt_r    <= idle_cnt_nx_s;
            tx_data_r     <= tx_data_nx_s;
            new_tx_r      <= new_tx_nx_s;
            last_byte_r   <= last_byte_nx_s;
        end
    end

    assign byte_ready  = ready_s;
    assign grant       = grant_r;
    assign tx_data     = tx_data_r;
    assign new_tx_data = new_tx_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a transaction-level reference of the arbitration rules.
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, byte_valid, byte_last, byte_ready, grant;
    logic [8*N-1:0] byte_data;
    logic [7:0]     tx_data;
    logic           new_tx_data, tx_busy;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_last   (byte_last),
        .byte_ready  (byte_ready),
        .grant       (grant),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] src_q [N][$];
    logic [N-1:0] valid_mask, drop_mask;
    bit         rnd_mode, refill, chk_en;
    int         m_owner, m_last, m_to;
    bit         m_settle, m_end, m_strobe;
    logic [7:0] m_data;
    int         grant_log[$];
    int         gap_log[$];
    logic [7:0] strobe_log[$];
    int         zero_run, strobe_cnt, g1;
    logic [N-1:0] prev_grant;
    int         exp_order[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
`ifdef UART_ARB_PRIORITY_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_last   = N - 1;
        m_to     = 0;
        m_settle = 1'b0;
        m_end    = 1'b0;
        m_strobe = 1'b0;
        m_data   = 8'h00;
    endtask

    // One clock: drive sources at negedge, check handshake, advance reference, check outputs.
    task automatic cycle();
        logic [N-1:0] exp_rdy, obs_rdy;
        logic [7:0]   cur [N];
        int           len;
        @(negedge clk);
        if (rnd_mode) begin
            valid_mask = N'($urandom);
            tx_busy    = ($urandom_range(0, 3) == 0);
            drop_mask  = ($urandom_range(0, 19) == 0) ? N'($urandom) : '0;
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) src_q[i].push_back(8'($urandom));
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (refill && src_q[i].size() == 0) src_q[i].push_back(8'($urandom));
            cur[i]              = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
            req[i]              = (src_q[i].size() != 0) && !drop_mask[i];
            byte_valid[i]       = (src_q[i].size() != 0) && valid_mask[i];
            byte_last[i]        = (src_q[i].size() == 1);
            byte_data[8*i +: 8] = cur[i];
        end
        #1;
        obs_rdy = byte_ready;
        exp_rdy = '0;
        if (m_owner >= 0 && !m_settle && req[m_owner] && byte_valid[m_owner] && !tx_busy)
            exp_rdy[m_owner] = 1'b1;
        if (chk_en) chk("byte_ready", obs_rdy, exp_rdy);
        @(posedge clk);
        m_strobe = 1'b0;
        if (rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            m_owner = rr_pick(req, m_last);
            m_to    = 0;
        end else if (m_settle) begin
            m_settle = 1'b0;
            m_to     = 0;
            if (m_end) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else if (!req[m_owner] || (!exp_rdy[m_owner] && m_to == TO - 1)) begin
            m_last  = m_owner;
            m_owner = -1;
            m_to    = 0;
        end else if (exp_rdy[m_owner]) begin
            m_strobe = 1'b1;
            m_data   = cur[m_owner];
            m_end    = byte_last[m_owner];
            m_settle = 1'b1;
            m_to     = 0;
        end else begin
            m_to++;
        end
        if (!rst) begin
            for (int i = 0; i < N; i++)
                if (obs_rdy[i] === 1'b1 && src_q[i].size() != 0) void'(src_q[i].pop_front());
        end
        #1;
        if (chk_en) begin
            chk("grant", grant, (m_owner >= 0) ? (1 << m_owner) : 0);
            chk("new_tx_data", new_tx_data, m_strobe);
            chk("tx_data", tx_data, m_data);
        end
        if (new_tx_data === 1'b1) begin
            strobe_log.push_back(tx_data);
            strobe_cnt++;
        end
        if (grant != '0 && grant !== prev_grant) begin
            grant_log.push_back($clog2(grant));
            gap_log.push_back(zero_run);
        end
        zero_run   = (grant == '0) ? zero_run + 1 : 0;
        prev_grant = grant;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) src_q[i].delete();
    endtask

    initial begin
        rst = 1'b1; req = '0; byte_valid = '0; byte_last = '0; byte_data = '0; tx_busy = 1'b0;
        valid_mask = '1; drop_mask = '0; rnd_mode = 1'b0; refill = 1'b0; chk_en = 1'b0;
        zero_run = 0; prev_grant = '0; strobe_cnt = 0;
`ifdef UART_ARB_PRIORITY_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 0};
`endif
        model_reset();
        repeat (3) cycle();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_grant", grant, 0);
        chk("reset_new_tx_data", new_tx_data, 0);
        chk("reset_tx_data", tx_data, 8'h00);

        // "Hi" from requester 0.
        src_q[0].push_back(8'h48);
        src_q[0].push_back(8'h69);
        strobe_log.delete();
        repeat (8) cycle();
        chk("hi_strobe_count", strobe_log.size(), 2);
        if (strobe_log.size() == 2) begin
            chk("hi_byte0", strobe_log[0], 8'h48);
            chk("hi_byte1", strobe_log[1], 8'h69);
        end
        chk("hi_grant_end", grant, 0);

        // Requester 1 granted but never offers a byte: timeout, then requester 2.
        grant_log.delete();
        valid_mask = '0;
        src_q[1].push_back(8'hA1);
        src_q[2].push_back(8'hB2);
        g1 = 0;
        for (int c = 0; c < 30; c++) begin
            cycle();
            if (grant == 3'b010) g1++;
        end
        chk("timeout_cycles", g1, TO);
        chk("timeout_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("timeout_first", grant_log[0], 1);
            chk("timeout_next", grant_log[1], 2);
        end
        clear_sources();
        valid_mask = '1;
        repeat (4) cycle();

        // All three request continuously with 1-byte messages.
        grant_log.delete();
        gap_log.delete();
        refill = 1'b1;
        repeat (16) cycle();
        refill = 1'b0;
        clear_sources();
        repeat (4) cycle();
        chk("rr_grant_count", grant_log.size() >= 4, 1);
        if (grant_log.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk($sformatf("rr_order%0d", k), grant_log[k], exp_order[k]);
            for (int k = 1; k < 4; k++) chk($sformatf("rr_gap%0d", k), gap_log[k], 1);
        end

        // Transmitter busy for 50 cycles while a byte waits.
        src_q[0].push_back(8'h5A);
        tx_busy    = 1'b1;
        strobe_cnt = 0;
        strobe_log.delete();
        repeat (50) cycle();
        chk("busy_no_strobe", strobe_cnt, 0);
        tx_busy = 1'b0;
        for (int c = 0; c < 20 && strobe_cnt == 0; c++) cycle();
        chk("busy_strobe_after", strobe_cnt, 1);
        if (strobe_log.size() == 1) chk("busy_strobe_data", strobe_log[0], 8'h5A);
        repeat (3) cycle();

        // Owner withdraws its request mid-message.
        src_q[1].push_back(8'hC3);
        src_q[1].push_back(8'hC4);
        valid_mask = '0;
        for (int c = 0; c < 10 && grant !== 3'b010; c++) cycle();
        chk("drop_granted", grant, 3'b010);
        drop_mask  = 3'b010;
        strobe_cnt = 0;
        cycle();
        chk("drop_grant", grant, 0);
        chk("drop_strobe", new_tx_data, 0);
        clear_sources();
        drop_mask  = '0;
        valid_mask = '1;
        repeat (3) cycle();
        chk("drop_no_send", strobe_cnt, 0);

        // Random traffic.
        rnd_mode = 1'b1;
        repeat (800) cycle();
        rnd_mode   = 1'b0;
        tx_busy    = 1'b0;
        valid_mask = '1;
        drop_mask  = '0;
        clear_sources();
        repeat (6) cycle();

        // Reset while settling after the first byte of a message.
        src_q[0].push_back(8'h11);
        src_q[0].push_back(8'h22);
        src_q[0].push_back(8'h33);
        strobe_cnt = 0;
        for (int c = 0; c < 20 && strobe_cnt == 0; c++) cycle();
        chk("rst_pre_strobe", strobe_cnt, 1);
        rst = 1'b1;
        cycle();
        chk("rst_grant", grant, 0);
        chk("rst_new_tx_data", new_tx_data, 0);
        rst = 1'b0;
        clear_sources();
        strobe_cnt = 0;
        repeat (8) cycle();
        chk("rst_no_resume", strobe_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of byte-stream requesters sharing the UART transmitter.
REQ-002 Parameter TIMEOUT, default 1024: idle cycles tolerated from a granted requester before its grant is revoked.
REQ-003 clk  input  1  clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NUM_REQ  per-requester request to send one message.
REQ-006 byte_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 byte_valid  input  NUM_REQ  byte_data of requester i is valid.
REQ-008 byte_last  input  NUM_REQ  current byte is the final byte of the message.
REQ-009 byte_ready  output  NUM_REQ  byte of requester i is accepted this cycle; combinational.
REQ-010 grant  output  NUM_REQ  one-hot registered grant; all zero when no owner.
REQ-011 tx_data  output  8  byte to UART transmitter; registered.
REQ-012 new_tx_data  output  1  one-cycle strobe to UART transmitter; registered.
REQ-013 tx_busy  input  1  UART transmitter busy.

Function
REQ-014 States: IDLE, ACTIVE, SETTLE; encoding 2 bits.
REQ-015 IDLE: grant=0; if any req bit set, the winner's grant bit is set on the next edge and the state goes to ACTIVE.
REQ-016 Winner selection: round-robin, search starts at (last_winner+1) mod NUM_REQ; last_winner updates only when a grant is released.
REQ-017 ACTIVE: byte_ready[g]=1 iff byte_valid[g] && !tx_busy; all other byte_ready bits are always 0.
REQ-018 On acceptance, tx_data<=byte_data[g] and new_tx_data<=1 on the same edge; the state goes to SETTLE.
REQ-019 new_tx_data SHALL be high for exactly one cycle per accepted byte; it is never asserted while tx_busy was high in the accepting cycle.
REQ-020 SETTLE lasts exactly one cycle, covering tx_busy rise latency; the state then goes to ACTIVE, or to IDLE with grant cleared if the accepted byte had byte_last=1.
REQ-021 Requester drops req while in ACTIVE: grant is released on the next edge, no byte is sent, and the state goes to IDLE.
REQ-022 Timeout counter: cleared on entry to ACTIVE and on every acceptance; increments each ACTIVE cycle without acceptance; on reaching TIMEOUT-1 the grant is released and the state goes to IDLE.
REQ-023 Simultaneous release and new request: IDLE always spends one cycle with grant=0 before the next grant (no back-to-back regrant).
REQ-024 tx_data holds its last value between strobes.

Reset
REQ-025 On rst: state=IDLE, grant=0, new_tx_data=0, tx_data=8'h00, last_winner=NUM_REQ-1 (so requester 0 wins first), timeout counter=0.
REQ-026 rst mid-message aborts the message; no further strobe is issued for it.

Configuration
REQ-027 Macro UART_ARB_PRIORITY_EN defined: requester 0 wins over all others whenever it requests in IDLE; round-robin applies among the rest. Undefined: pure round-robin among all requesters per REQ-016.

Structure
REQ-028 Package uart_arb_pkg holds the state enum, the state width, and the default TIMEOUT constant.
REQ-029 Sub-module rr_arbiter: combinational round-robin pick (inputs: req, last_winner; output: one-hot winner), instantiated once.

Verification
REQ-030 Reset, then req=3'b001, byte stream "Hi" (0x48, 0x69 with last) -> two one-cycle new_tx_data strobes with tx_data 0x48 then 0x69, then grant=0.
REQ-031 req=3'b111 held, each message 1 byte -> grants in order 0, 1, 2, 0, each separated by one idle cycle.
REQ-032 tx_busy held high 50 cycles while byte_valid=1 -> no byte_ready and no strobe until tx_busy falls; strobe follows in that cycle's edge.
REQ-033 Grant to requester 1, byte_valid stays 0 with TIMEOUT=16 -> grant released after 16 cycles; requester 2 is granted next.
REQ-034 rst asserted in SETTLE mid-message -> next cycle grant=0 and new_tx_data=0; message not resumed.
REQ-035 UART_ARB_PRIORITY_EN defined, req=3'b111 continuous -> requester 0 granted every arbitration.
